// File: rtl/pong_pkg.sv
// pong_pkg -- shared definitions for the pong game controller.
//   state_e     : controller FSM state encoding
//   SIDE_*      : serve_side codes (bit1 = left/P1 serves, bit0 = right/P2 serves)
//   EV_*        : bit positions of the four event inputs in the edge-detect vector
//   *_DEF       : default values for WIN_SCORE, POINT_HOLD, SERVE_DELAY
//   sat_inc     : score increment that saturates at a limit
package pong_pkg;

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_POINT = 2'd2,
      ST_OVER  = 2'd3
   } state_e;

   localparam logic [1:0] SIDE_L    = 2'b10;
   localparam logic [1:0] SIDE_R    = 2'b01;
   localparam logic [1:0] SIDE_NONE = 2'b00;

   localparam int EV_P1 = 0;
   localparam int EV_P2 = 1;
   localparam int EV_ML = 2;
   localparam int EV_MR = 3;
   localparam int EV_N  = 4;

   localparam int WIN_SCORE_DEF   = 9;
   localparam int POINT_HOLD_DEF  = 30;
   localparam int SERVE_DELAY_DEF = 120;

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/pong_game_ctrl_edge_det.sv
// edge_det -- rising-edge detector for a vector of level inputs.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset (clears history)
//   in_sig  : WIDTH level inputs
//   rise    : WIDTH pulses, high while input is 1 and previous sample was 0
module edge_det #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_sig,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_d;

   always_comb begin
      prev_d = in_sig;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end

   // Rise uses the live input so the consuming FSM acts on the same edge
   // that first samples the new level.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign rise[gi] = in_sig[gi] & ~prev_q[gi];
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl -- serve / play / point / game-over sequencing for pong.
//   clk, rst_n         : clock, asynchronous active-low reset
//   frame_tick         : one-cycle pulse per frame
//   p1_srv, p2_srv     : raw serve button levels
//   miss_l, miss_r     : ball touching left / right wall (levels)
//   ball_run, ball_dir : ball motion enable, direction (1 = right)
//   ball_reset         : one-cycle re-centre pulse
//   serve_side         : {P1 serves, P2 serves}
//   score1, score2     : BCD points
//   game_over, beep_pt : game ended, point-scored beep request
// Optional feature: define PONG_AUTO_SERVE_EN to serve automatically after
// SERVE_DELAY frame ticks in SERVE.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = WIN_SCORE_DEF,
   parameter int POINT_HOLD  = POINT_HOLD_DEF,
   parameter int SERVE_DELAY = SERVE_DELAY_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       p1_srv,
   input  logic       p2_srv,
   input  logic       miss_l,
   input  logic       miss_r,
   output logic       ball_run,
   output logic       ball_dir,
   output logic       ball_reset,
   output logic [1:0] serve_side,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       game_over,
   output logic       beep_pt
);

   localparam int HOLD_W = $clog2(POINT_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POINT_HOLD - 1);
   localparam logic [3:0] WIN_S = 4'(WIN_SCORE);

   logic [EV_N-1:0] rise;

   edge_det #(.WIDTH(EV_N)) u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_sig ({miss_r, miss_l, p2_srv, p1_srv}),
      .rise   (rise)
   );

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              ball_run_q, ball_run_d;
   logic              ball_dir_q, ball_dir_d;
   logic              ball_reset_q, ball_reset_d;
   logic [1:0]        serve_side_q, serve_side_d;
   logic [3:0]        score1_q, score1_d;
   logic [3:0]        score2_q, score2_d;
   logic              game_over_q, game_over_d;
   logic              beep_pt_q, beep_pt_d;
   logic              serve_go;

`ifdef PONG_AUTO_SERVE_EN
   localparam int SRV_W = $clog2(SERVE_DELAY + 1);
   localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_DELAY - 1);
   logic [SRV_W-1:0] srv_cnt_q, srv_cnt_d;
`endif

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      ball_dir_d   = ball_dir_q;
      ball_reset_d = 1'b0;
      serve_side_d = serve_side_q;
      score1_d     = score1_q;
      score2_d     = score2_q;
      serve_go     = 1'b0;
`ifdef PONG_AUTO_SERVE_EN
      srv_cnt_d    = srv_cnt_q;
`endif

      case (state_q)
         ST_SERVE: begin
            // Only the flagged server's button counts.
            serve_go = (serve_side_q == SIDE_L && rise[EV_P1]) ||
                       (serve_side_q == SIDE_R && rise[EV_P2]);
`ifdef PONG_AUTO_SERVE_EN
            if (frame_tick) begin
               if (srv_cnt_q == SRV_LAST) begin
                  serve_go = 1'b1;
               end else begin
                  srv_cnt_d = srv_cnt_q + SRV_W'(1);
               end
            end
`endif
            if (serve_go) begin
               state_d      = ST_PLAY;
               ball_dir_d   = serve_side_q[1];   // P1 serves rightwards
               serve_side_d = SIDE_NONE;
            end
         end
         ST_PLAY: begin
            // Left miss wins a tie: P2 is credited.
            if (rise[EV_ML]) begin
               score2_d     = sat_inc(score2_q, WIN_S);
               serve_side_d = SIDE_L;
               state_d      = ST_POINT;
               hold_d       = '0;
            end else if (rise[EV_MR]) begin
               score1_d     = sat_inc(score1_q, WIN_S);
               serve_side_d = SIDE_R;
               state_d      = ST_POINT;
               hold_d       = '0;
            end
         end
         ST_POINT: begin
            if (frame_tick) begin
               if (hold_q == HOLD_LAST) begin
                  if (score1_q == WIN_S || score2_q == WIN_S) begin
                     state_d = ST_OVER;
                  end else begin
                     state_d      = ST_SERVE;
                     ball_reset_d = 1'b1;
                  end
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         ST_OVER: begin
            if (rise[EV_P1] || rise[EV_P2]) begin
               score1_d     = '0;
               score2_d     = '0;
               serve_side_d = SIDE_L;
               ball_reset_d = 1'b1;
               state_d      = ST_SERVE;
            end
         end
         default: state_d = ST_SERVE;
      endcase

`ifdef PONG_AUTO_SERVE_EN
      if (state_d == ST_SERVE && state_q != ST_SERVE) begin
         srv_cnt_d = '0;
      end
`endif

      // Level outputs follow the next state so they are registered alongside it.
      ball_run_d  = (state_d == ST_PLAY);
      game_over_d = (state_d == ST_OVER);
      beep_pt_d   = (state_d == ST_POINT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_SERVE;
         hold_q       <= '0;
         ball_run_q   <= 1'b0;
         ball_dir_q   <= 1'b1;
         ball_reset_q <= 1'b0;
         serve_side_q <= SIDE_L;
         score1_q     <= '0;
         score2_q     <= '0;
         game_over_q  <= 1'b0;
         beep_pt_q    <= 1'b0;
`ifdef PONG_AUTO_SERVE_EN
         srv_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         ball_run_q   <= ball_run_d;
         ball_dir_q   <= ball_dir_d;
         ball_reset_q <= ball_reset_d;
         serve_side_q <= serve_side_d;
         score1_q     <= score1_d;
         score2_q     <= score2_d;
         game_over_q  <= game_over_d;
         beep_pt_q    <= beep_pt_d;
`ifdef PONG_AUTO_SERVE_EN
         srv_cnt_q    <= srv_cnt_d;
`endif
      end
   end

   assign ball_run   = ball_run_q;
   assign ball_dir   = ball_dir_q;
   assign ball_reset = ball_reset_q;
   assign serve_side = serve_side_q;
   assign score1     = score1_q;
   assign score2     = score2_q;
   assign game_over  = game_over_q;
   assign beep_pt    = beep_pt_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl -- directed scenarios plus randomized play, every cycle
// compared against a game-level model of the controller.
module tb_pong_game_ctrl;

   localparam int WIN   = 9;
   localparam int HOLD  = 30;
   localparam int DELAY = 120;

   // model phases
   localparam int PH_SERVE = 0;
   localparam int PH_PLAY  = 1;
   localparam int PH_POINT = 2;
   localparam int PH_OVER  = 3;

   localparam logic [14:0] RESET_VEC = 15'b0_1_0_10_0000_0000_0_0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       p1_srv = 1'b0, p2_srv = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
   logic       ball_run, ball_dir, ball_reset, game_over, beep_pt;
   logic [1:0] serve_side;
   logic [3:0] score1, score2;

   int total = 0;
   int bad   = 0;

   pong_game_ctrl #(.WIN_SCORE(WIN), .POINT_HOLD(HOLD), .SERVE_DELAY(DELAY)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .p1_srv     (p1_srv),
      .p2_srv     (p2_srv),
      .miss_l     (miss_l),
      .miss_r     (miss_r),
      .ball_run   (ball_run),
      .ball_dir   (ball_dir),
      .ball_reset (ball_reset),
      .serve_side (serve_side),
      .score1     (score1),
      .score2     (score2),
      .game_over  (game_over),
      .beep_pt    (beep_pt)
   );

   always #5 clk = ~clk;

   // ---------------- game-level model ----------------
   int m_phase, m_s1, m_s2, m_side;   // m_side: 1 = P1 serves, 2 = P2 serves, 0 = none
   int m_hold, m_wait;
   bit m_dir, m_pulse;
   bit pv_p1, pv_p2, pv_ml, pv_mr;

   task automatic model_reset();
      m_phase = PH_SERVE; m_s1 = 0; m_s2 = 0; m_side = 1;
      m_hold = 0; m_wait = 0; m_dir = 1'b1; m_pulse = 1'b0;
      pv_p1 = 0; pv_p2 = 0; pv_ml = 0; pv_mr = 0;
   endtask

   task automatic model_step();
      bit r1, r2, rl, rr, go;
      r1 = p1_srv & ~pv_p1;
      r2 = p2_srv & ~pv_p2;
      rl = miss_l & ~pv_ml;
      rr = miss_r & ~pv_mr;
      m_pulse = 1'b0;
      go = 1'b0;
      case (m_phase)
         PH_SERVE: begin
            go = (m_side == 1 && r1) || (m_side == 2 && r2);
`ifdef PONG_AUTO_SERVE_EN
            if (frame_tick) begin
               m_wait++;
               if (m_wait == DELAY) go = 1'b1;
            end
`endif
            if (go) begin
               m_dir = (m_side == 1);
               m_side = 0;
               m_phase = PH_PLAY;
            end
         end
         PH_PLAY: begin
            if (rl) begin
               if (m_s2 < WIN) m_s2++;
               m_side = 1; m_phase = PH_POINT; m_hold = 0;
            end else if (rr) begin
               if (m_s1 < WIN) m_s1++;
               m_side = 2; m_phase = PH_POINT; m_hold = 0;
            end
         end
         PH_POINT: begin
            if (frame_tick) begin
               m_hold++;
               if (m_hold == HOLD) begin
                  if (m_s1 == WIN || m_s2 == WIN) begin
                     m_phase = PH_OVER;
                  end else begin
                     m_phase = PH_SERVE; m_pulse = 1'b1; m_wait = 0;
                  end
               end
            end
         end
         default: begin
            if (r1 || r2) begin
               m_s1 = 0; m_s2 = 0; m_side = 1; m_pulse = 1'b1;
               m_phase = PH_SERVE; m_wait = 0;
            end
         end
      endcase
      pv_p1 = p1_srv; pv_p2 = p2_srv; pv_ml = miss_l; pv_mr = miss_r;
   endtask

   function automatic logic [14:0] model_vec();
      logic [1:0] sb;
      sb = (m_side == 1) ? 2'b10 : (m_side == 2) ? 2'b01 : 2'b00;
      return {m_phase == PH_PLAY, m_dir, m_pulse, sb, 4'(m_s1), 4'(m_s2),
              m_phase == PH_OVER, m_phase == PH_POINT};
   endfunction

   function automatic logic [14:0] dut_vec();
      return {ball_run, ball_dir, ball_reset, serve_side, score1, score2, game_over, beep_pt};
   endfunction

   // ---------------- checks ----------------
   task automatic check_model(input string tag);
      logic [14:0] d, m;
      d = dut_vec();
      m = model_vec();
      total++;
      if (d !== m) begin
         bad++;
         $display("FAIL model_%s t=%0t dut=%b expected=%b", tag, $time, d, m);
      end
   endtask

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle from a negedge, advance model at posedge, compare at next negedge.
   task automatic cyc(input bit a, input bit b, input bit l, input bit r, input bit t);
      p1_srv = a; p2_srv = b; miss_l = l; miss_r = r; frame_tick = t;
      @(posedge clk);
      if (rst_n) model_step(); else model_reset();
      @(negedge clk);
      check_model("cyc");
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset applied between clock edges; outputs must clear at once.
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_lit({"async_reset_", tag}, 32'(dut_vec()), 32'(RESET_VEC));
      check_model("reset");
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      idle();
   endtask

   task automatic play_point(input bit p1_wins);
      int n;
      if (m_side == 1) cyc(1, 0, 0, 0, 0); else cyc(0, 1, 0, 0, 0);
      idle();
      if (p1_wins) cyc(0, 0, 0, 1, 0); else cyc(0, 0, 1, 0, 0);
      idle();
      n = 0;
      while (m_phase == PH_POINT && n < 200) begin
         cyc(0, 0, 0, 0, 1);
         n++;
      end
      check_lit("point_hold_bound", 32'(m_phase == PH_POINT), 32'd0);
   endtask

   initial begin
      int ticks;
      model_reset();
      @(negedge clk);
      do_reset("power_on");

      // Wrong-side button ignored, then P1 serves right.
      cyc(0, 1, 0, 0, 0);
      idle();
      check_lit("p2_ignored_run", 32'(ball_run), 32'd0);
      check_lit("p2_ignored_side", 32'(serve_side), 32'h2);
      cyc(1, 0, 0, 0, 0);
      check_lit("serve_run", 32'(ball_run), 32'd1);
      check_lit("serve_dir", 32'(ball_dir), 32'd1);
      check_lit("serve_side_none", 32'(serve_side), 32'd0);
      idle();

      // miss_r held 5 cycles scores once.
      cyc(0, 0, 0, 1, 0);
      check_lit("missr_score1", 32'(score1), 32'd1);
      check_lit("missr_side", 32'(serve_side), 32'h1);
      check_lit("missr_beep", 32'(beep_pt), 32'd1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
      check_lit("missr_held_score1", 32'(score1), 32'd1);
      ticks = 0;
      for (int i = 0; i < 200; i++) begin
         if (beep_pt && (i % 2 == 0)) ticks++;
         cyc(0, 0, 0, 0, (i % 2 == 0));
         if (ball_reset) break;
      end
      check_lit("beep_ticks", 32'(ticks), 32'd30);
      check_lit("ball_reset_seen", 32'(ball_reset), 32'd1);
      check_lit("beep_off", 32'(beep_pt), 32'd0);
      idle();
      check_lit("ball_reset_one_cycle", 32'(ball_reset), 32'd0);

      // Simultaneous misses credit P2 only.
      do_reset("before_tie");
      cyc(1, 0, 0, 0, 0);
      idle();
      cyc(0, 0, 1, 1, 0);
      check_lit("tie_score2", 32'(score2), 32'd1);
      check_lit("tie_score1", 32'(score1), 32'd0);
      check_lit("tie_side", 32'(serve_side), 32'h2);
      cyc(0, 0, 0, 0, 1);

      // Reset in the middle of POINT abandons the point.
      do_reset("mid_point");
      check_lit("post_reset_score2", 32'(score2), 32'd0);
      check_lit("post_reset_score1", 32'(score1), 32'd0);

      // P1 plays to 9; extra miss after 9 must not change anything.
      for (int k = 0; k < 9; k++) play_point(1);
      check_lit("over_flag", 32'(game_over), 32'd1);
      check_lit("over_score1", 32'(score1), 32'd9);
      check_lit("over_run", 32'(ball_run), 32'd0);
      cyc(0, 0, 0, 1, 1);
      idle();
      check_lit("over_miss_ignored", 32'(score1), 32'd9);
      cyc(0, 1, 0, 0, 0);
      check_lit("restart_score1", 32'(score1), 32'd0);
      check_lit("restart_side", 32'(serve_side), 32'h2);
      check_lit("restart_pulse", 32'(ball_reset), 32'd1);
      check_lit("restart_over", 32'(game_over), 32'd0);
      idle();

      // Serve without buttons.
`ifdef PONG_AUTO_SERVE_EN
      for (int i = 0; i < 200; i++) begin
         cyc(0, 0, 0, 0, 1);
         if (i == 118) check_lit("auto_not_yet", 32'(ball_run), 32'd0);
         if (i == 119) begin
            check_lit("auto_serve_120", 32'(ball_run), 32'd1);
            break;
         end
      end
`else
      for (int i = 0; i < 200; i++) cyc(0, 0, 0, 0, 1);
      check_lit("no_auto_serve", 32'(ball_run), 32'd0);
`endif

      // Randomized play.
      do_reset("before_random");
      for (int i = 0; i < 6000; i++) begin
         bit a, b, l, r, t;
         a = ($urandom_range(0, 7) == 0) ? ~p1_srv : p1_srv;
         b = ($urandom_range(0, 7) == 0) ? ~p2_srv : p2_srv;
         l = ($urandom_range(0, 9) == 0) ? ~miss_l : miss_l;
         r = ($urandom_range(0, 9) == 0) ? ~miss_r : miss_r;
         t = ($urandom_range(0, 2) == 0);
         cyc(a, b, l, r, t);
         if ($urandom_range(0, 1999) == 0) do_reset("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
